// File: rtl/otsu_pkg.sv
// ---------------------------------------------------------------------------
// otsu_pkg
// Shared definitions for the Otsu threshold sweep controller:
//   - default parameter widths
//   - sweep state enumeration
//   - num_bins(): histogram depth derived from the bin address width
// No ports (package).
// ---------------------------------------------------------------------------
package otsu_pkg;

   localparam int unsigned DEF_BIN_WIDTH       = 32'd8;
   localparam int unsigned DEF_COUNT_WIDTH     = 32'd32;
   localparam int unsigned DEF_INTENSITY_WIDTH = 32'd32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TOTAL    = 3'd1,
      ARM      = 3'd2,
      STREAM   = 3'd3,
      WAIT_ACC = 3'd4,
      DONE     = 3'd5
   } otsu_state_e;

   // Number of histogram bins addressed by a bin_width-bit address.
   function automatic int unsigned num_bins(input int unsigned bin_width);
      return 32'd1 << bin_width;
   endfunction

endpackage

// File: rtl/otsu_sweep_controller_if.sv
// ---------------------------------------------------------------------------
// otsu_sweep_controller_if
// Bundles the control handshake, histogram read port and accumulator
// stream of the Otsu sweep controller.
//   master : controller side (drives busy/done, hist reads, acc stream)
//   slave  : environment side (drives start, hist_data, acc_done)
// Optional: OTSU_SWEEP_HIST_CLEAR_EN adds the histogram write-back port
// (hist_wr_en, hist_wr_addr, hist_wr_data) used to zero bins on the fly.
// ---------------------------------------------------------------------------
interface otsu_sweep_controller_if #(
   parameter int unsigned BIN_WIDTH       = otsu_pkg::DEF_BIN_WIDTH,
   parameter int unsigned COUNT_WIDTH     = otsu_pkg::DEF_COUNT_WIDTH,
   parameter int unsigned INTENSITY_WIDTH = otsu_pkg::DEF_INTENSITY_WIDTH
);
   logic                       start;
   logic                       busy;
   logic                       done;
   logic                       hist_rd_en;
   logic [BIN_WIDTH-1:0]       hist_addr;
   logic [COUNT_WIDTH-1:0]     hist_data;
   logic                       acc_start;
   logic [COUNT_WIDTH-1:0]     acc_total_pixels;
   logic [INTENSITY_WIDTH-1:0] acc_total_sum;
   logic [COUNT_WIDTH-1:0]     acc_cum_count;
   logic [INTENSITY_WIDTH-1:0] acc_cum_sum;
   logic                       acc_valid;
   logic                       acc_last;
   logic                       acc_done;
`ifdef OTSU_SWEEP_HIST_CLEAR_EN
   logic                       hist_wr_en;
   logic [BIN_WIDTH-1:0]       hist_wr_addr;
   logic [COUNT_WIDTH-1:0]     hist_wr_data;

   modport master (
      input  start, hist_data, acc_done,
      output busy, done, hist_rd_en, hist_addr,
      output acc_start, acc_total_pixels, acc_total_sum,
      output acc_cum_count, acc_cum_sum, acc_valid, acc_last,
      output hist_wr_en, hist_wr_addr, hist_wr_data
   );
   modport slave (
      output start, hist_data, acc_done,
      input  busy, done, hist_rd_en, hist_addr,
      input  acc_start, acc_total_pixels, acc_total_sum,
      input  acc_cum_count, acc_cum_sum, acc_valid, acc_last,
      input  hist_wr_en, hist_wr_addr, hist_wr_data
   );
`else
   modport master (
      input  start, hist_data, acc_done,
      output busy, done, hist_rd_en, hist_addr,
      output acc_start, acc_total_pixels, acc_total_sum,
      output acc_cum_count, acc_cum_sum, acc_valid, acc_last
   );
   modport slave (
      output start, hist_data, acc_done,
      input  busy, done, hist_rd_en, hist_addr,
      input  acc_start, acc_total_pixels, acc_total_sum,
      input  acc_cum_count, acc_cum_sum, acc_valid, acc_last
   );
`endif
endinterface

// File: rtl/otsu_sweep_controller_bin_scan_sequencer.sv
// ---------------------------------------------------------------------------
// bin_scan_sequencer
// Issues one read per cycle for bins 0..NUM_BINS-1 after a scan_go pulse and
// tracks the 1-cycle read latency with a registered valid/last/index triple.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   scan_go    : pulse that starts a scan (first read issued next cycle)
//   rd_en      : histogram read strobe
//   rd_addr    : histogram read address
//   rd_valid   : hist_data carries a returned bin this cycle
//   rd_last    : the returned bin is NUM_BINS-1
//   ret_addr   : index of the returned bin
// ---------------------------------------------------------------------------
module bin_scan_sequencer
   import otsu_pkg::*;
#(
   parameter int unsigned BIN_WIDTH = DEF_BIN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 scan_go,
   output logic                 rd_en,
   output logic [BIN_WIDTH-1:0] rd_addr,
   output logic                 rd_valid,
   output logic                 rd_last,
   output logic [BIN_WIDTH-1:0] ret_addr
);
   localparam logic [BIN_WIDTH-1:0] LAST_ADDR = BIN_WIDTH'(num_bins(BIN_WIDTH) - 32'd1);

   logic                 rd_en_r;
   logic [BIN_WIDTH-1:0] addr_r;
   logic                 rd_valid_r;
   logic                 rd_last_r;
   logic [BIN_WIDTH-1:0] ret_addr_r;

   // Address counter and read-in-flight pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_r    <= 1'b0;
         addr_r     <= {BIN_WIDTH{1'b0}};
         rd_valid_r <= 1'b0;
         rd_last_r  <= 1'b0;
         ret_addr_r <= {BIN_WIDTH{1'b0}};
      end else begin
         if (scan_go) begin
            rd_en_r <= 1'b1;
            addr_r  <= {BIN_WIDTH{1'b0}};
         end else if (rd_en_r) begin
            // Park the counter at 0 once the last read has been issued.
            if (addr_r == LAST_ADDR) begin
               rd_en_r <= 1'b0;
               addr_r  <= {BIN_WIDTH{1'b0}};
            end else begin
               addr_r  <= addr_r + {{(BIN_WIDTH-1){1'b0}}, 1'b1};
            end
         end else begin
            rd_en_r <= 1'b0;
            addr_r  <= addr_r;
         end
         rd_valid_r <= rd_en_r;
         rd_last_r  <= rd_en_r && (addr_r == LAST_ADDR);
         ret_addr_r <= addr_r;
      end
   end

   assign rd_en    = rd_en_r;
   assign rd_addr  = addr_r;
   assign rd_valid = rd_valid_r;
   assign rd_last  = rd_last_r;
   assign ret_addr = ret_addr_r;

endmodule

// File: rtl/otsu_sweep_controller.sv
// ---------------------------------------------------------------------------
// otsu_sweep_controller
// Runs one Otsu sweep over a histogram RAM: pass 1 totals the pixel count
// and intensity sum, pass 2 streams inclusive cumulative count/sum beats to
// the prefix-accumulator stage, then waits for acc_done and pulses done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : otsu_sweep_controller_if.master (start/busy/done, histogram
//                read port, accumulator stream and acc_done)
// Optional: OTSU_SWEEP_HIST_CLEAR_EN writes 0 to every bin as it is read in
// the streaming pass, leaving the histogram cleared for the next frame.
// ---------------------------------------------------------------------------
module otsu_sweep_controller
   import otsu_pkg::*;
#(
   parameter int unsigned BIN_WIDTH       = DEF_BIN_WIDTH,
   parameter int unsigned COUNT_WIDTH     = DEF_COUNT_WIDTH,
   parameter int unsigned INTENSITY_WIDTH = DEF_INTENSITY_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   otsu_sweep_controller_if.master bus
);
   localparam int unsigned PROD_WIDTH = BIN_WIDTH + COUNT_WIDTH;

   otsu_state_e                state_r, state_s;
   logic                       scan_go_s;
   logic                       rd_valid_s, rd_last_s;
   logic [BIN_WIDTH-1:0]       ret_addr_s;
   logic                       total_beat_s, stream_beat_s;
   logic [PROD_WIDTH-1:0]      prod_s;
   logic [COUNT_WIDTH-1:0]     total_pixels_r, total_pixels_s;
   logic [INTENSITY_WIDTH-1:0] total_sum_r, total_sum_s;
   logic [COUNT_WIDTH-1:0]     cum_count_r;
   logic [INTENSITY_WIDTH-1:0] cum_sum_r;
   logic [COUNT_WIDTH-1:0]     acc_total_pixels_r;
   logic [INTENSITY_WIDTH-1:0] acc_total_sum_r;
   logic                       busy_r, done_r, acc_start_r, acc_valid_r, acc_last_r;

   bin_scan_sequencer #(.BIN_WIDTH(BIN_WIDTH)) u_scan (
      .clk      (clk),
      .rst_n    (rst_n),
      .scan_go  (scan_go_s),
      .rd_en    (bus.hist_rd_en),
      .rd_addr  (bus.hist_addr),
      .rd_valid (rd_valid_s),
      .rd_last  (rd_last_s),
      .ret_addr (ret_addr_s)
   );

   assign total_beat_s  = (state_r == TOTAL)  && rd_valid_s;
   assign stream_beat_s = (state_r == STREAM) && rd_valid_s;
   assign prod_s        = PROD_WIDTH'(ret_addr_s) * PROD_WIDTH'(bus.hist_data);

   // Next-state decode; the sequencer is kicked from IDLE and from ARM.
   always_comb begin
      state_s   = state_r;
      scan_go_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s   = TOTAL;
               scan_go_s = 1'b1;
            end else begin
               state_s   = IDLE;
            end
         end
         TOTAL: begin
            if (rd_valid_s && rd_last_s) begin
               state_s = ARM;
            end else begin
               state_s = TOTAL;
            end
         end
         ARM: begin
            state_s   = STREAM;
            scan_go_s = 1'b1;
         end
         STREAM: begin
            if (rd_valid_s && rd_last_s) begin
               state_s = WAIT_ACC;
            end else begin
               state_s = STREAM;
            end
         end
         WAIT_ACC: begin
            if (bus.acc_done) begin
               state_s = DONE;
            end else begin
               state_s = WAIT_ACC;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Totals including the bin returning this cycle (sums wrap modulo width).
   always_comb begin
      total_pixels_s = total_pixels_r;
      total_sum_s    = total_sum_r;
      if (total_beat_s) begin
         total_pixels_s = total_pixels_r + bus.hist_data;
         total_sum_s    = total_sum_r + INTENSITY_WIDTH'(prod_s);
      end else begin
         total_pixels_s = total_pixels_r;
         total_sum_s    = total_sum_r;
      end
   end

   // State, registered control outputs and the accumulation registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r            <= IDLE;
         busy_r             <= 1'b0;
         done_r             <= 1'b0;
         acc_start_r        <= 1'b0;
         acc_valid_r        <= 1'b0;
         acc_last_r         <= 1'b0;
         total_pixels_r     <= {COUNT_WIDTH{1'b0}};
         total_sum_r        <= {INTENSITY_WIDTH{1'b0}};
         cum_count_r        <= {COUNT_WIDTH{1'b0}};
         cum_sum_r          <= {INTENSITY_WIDTH{1'b0}};
         acc_total_pixels_r <= {COUNT_WIDTH{1'b0}};
         acc_total_sum_r    <= {INTENSITY_WIDTH{1'b0}};
      end else begin
         state_r     <= state_s;
         busy_r      <= (state_s == TOTAL) || (state_s == ARM) ||
                        (state_s == STREAM) || (state_s == WAIT_ACC);
         done_r      <= (state_s == DONE);
         acc_start_r <= (state_s == ARM);
         acc_valid_r <= stream_beat_s;
         acc_last_r  <= stream_beat_s && rd_last_s;

         if ((state_r == IDLE) && scan_go_s) begin
            total_pixels_r <= {COUNT_WIDTH{1'b0}};
            total_sum_r    <= {INTENSITY_WIDTH{1'b0}};
         end else begin
            total_pixels_r <= total_pixels_s;
            total_sum_r    <= total_sum_s;
         end

         // Totals are published together with acc_start and then held.
         if ((state_r == TOTAL) && (state_s == ARM)) begin
            acc_total_pixels_r <= total_pixels_s;
            acc_total_sum_r    <= total_sum_s;
            cum_count_r        <= {COUNT_WIDTH{1'b0}};
            cum_sum_r          <= {INTENSITY_WIDTH{1'b0}};
         end else if (stream_beat_s) begin
            cum_count_r        <= cum_count_r + bus.hist_data;
            cum_sum_r          <= cum_sum_r + INTENSITY_WIDTH'(prod_s);
         end else begin
            cum_count_r        <= cum_count_r;
            cum_sum_r          <= cum_sum_r;
         end
      end
   end

   assign bus.busy             = busy_r;
   assign bus.done             = done_r;
   assign bus.acc_start        = acc_start_r;
   assign bus.acc_total_pixels = acc_total_pixels_r;
   assign bus.acc_total_sum    = acc_total_sum_r;
   assign bus.acc_cum_count    = cum_count_r;
   assign bus.acc_cum_sum      = cum_sum_r;
   assign bus.acc_valid        = acc_valid_r;
   assign bus.acc_last         = acc_last_r;

`ifdef OTSU_SWEEP_HIST_CLEAR_EN
   // Zero each bin in the same cycle its streaming-pass data returns.
   assign bus.hist_wr_en   = stream_beat_s;
   assign bus.hist_wr_addr = stream_beat_s ? ret_addr_s : {BIN_WIDTH{1'b0}};
   assign bus.hist_wr_data = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_otsu_sweep_controller.sv
// ---------------------------------------------------------------------------
// tb_otsu_sweep_controller
// Directed bench: a 4-bin instance (bus/dut) with a histogram RAM model and
// an acc_done responder, plus a 256-bin instance (bz/dut_z) fed an all-zero
// histogram with acc_done held high. Honours OTSU_SWEEP_HIST_CLEAR_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_otsu_sweep_controller;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   otsu_sweep_controller_if #(.BIN_WIDTH(2), .COUNT_WIDTH(32), .INTENSITY_WIDTH(32)) bus ();
   otsu_sweep_controller_if #(.BIN_WIDTH(8), .COUNT_WIDTH(32), .INTENSITY_WIDTH(32)) bz ();

   otsu_sweep_controller #(.BIN_WIDTH(2), .COUNT_WIDTH(32), .INTENSITY_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   otsu_sweep_controller #(.BIN_WIDTH(8), .COUNT_WIDTH(32), .INTENSITY_WIDTH(32)) dut_z (
      .clk(clk), .rst_n(rst_n), .bus(bz));

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- histogram RAM model (4 bins) ----------------
   logic [31:0] mem [0:3];
   logic [31:0] ld_vals [0:3];
   logic        ld_en = 1'b0;
   logic [31:0] hist_data_r;
   always @(posedge clk) begin
      if (ld_en) begin
         for (int i = 0; i < 4; i++) mem[i] <= ld_vals[i];
      end else begin
`ifdef OTSU_SWEEP_HIST_CLEAR_EN
         if (bus.hist_wr_en) mem[bus.hist_wr_addr] <= bus.hist_wr_data;
`endif
      end
      if (bus.hist_rd_en) hist_data_r <= mem[bus.hist_addr];
   end
   assign bus.hist_data = hist_data_r;

   assign bz.hist_data = 32'd0;
   assign bz.acc_done  = 1'b1;

   // ---------------- acc_done responder: 2 cycles after acc_last ----------------
   logic spur = 1'b0;
   int   cd   = 0;
   initial begin
      bus.acc_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.acc_done = 1'b0;
         if (cd == 1) bus.acc_done = 1'b1;
         if (cd > 0) cd--;
         if (bus.acc_last) cd = 2;
         if (spur) bus.acc_done = 1'b1;
      end
   end

   // ---------------- monitor ----------------
   int cyc = 0, beat_cnt = 0, start_cnt = 0, start_cyc = 0, done_cnt = 0;
   logic [31:0] cap_tp, cap_ts;
   logic [31:0] b_cc [0:63];
   logic [31:0] b_cs [0:63];
   logic        b_last [0:63];
   int          b_cyc [0:63];
   int zbeats = 0, zlast_cnt = 0, zlast_idx = -1, znz = 0, zstart = 0, zdone = 0;
   logic [31:0] ztp, zts;
`ifdef OTSU_SWEEP_HIST_CLEAR_EN
   int wr_cnt = 0;
   logic [1:0]  w_addr [0:63];
   logic [31:0] w_data [0:63];
`endif
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.acc_start) begin
            start_cnt++;
            start_cyc = cyc;
            cap_tp = bus.acc_total_pixels;
            cap_ts = bus.acc_total_sum;
         end
         if (bus.acc_valid) begin
            if (beat_cnt < 64) begin
               b_cc[beat_cnt]   = bus.acc_cum_count;
               b_cs[beat_cnt]   = bus.acc_cum_sum;
               b_last[beat_cnt] = bus.acc_last;
               b_cyc[beat_cnt]  = cyc;
            end
            beat_cnt++;
         end
         if (bus.done) done_cnt++;
`ifdef OTSU_SWEEP_HIST_CLEAR_EN
         if (bus.hist_wr_en) begin
            if (wr_cnt < 64) begin
               w_addr[wr_cnt] = bus.hist_wr_addr;
               w_data[wr_cnt] = bus.hist_wr_data;
            end
            wr_cnt++;
         end
`endif
         if (bz.acc_start) begin
            zstart++;
            ztp = bz.acc_total_pixels;
            zts = bz.acc_total_sum;
         end
         if (bz.acc_valid) begin
            if (bz.acc_last) begin
               zlast_cnt++;
               zlast_idx = zbeats;
            end
            if ((bz.acc_cum_count != 32'd0) || (bz.acc_cum_sum != 32'd0)) znz++;
            zbeats++;
         end
         if (bz.done) zdone++;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_hist(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
      ld_vals[0] = a; ld_vals[1] = b; ld_vals[2] = c; ld_vals[3] = d;
      @(negedge clk);
      ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   logic [31:0] exp_cc [0:3];
   logic [31:0] exp_cs [0:3];

   // One full sweep on the 4-bin instance; disturb re-pulses start mid-sweep.
   task automatic run_sweep(input string nm, input bit disturb,
                            input logic [31:0] etp, input logic [31:0] ets);
      int b0, s0, d0, k;
      bit got;
`ifdef OTSU_SWEEP_HIST_CLEAR_EN
      int w0;
      w0 = wr_cnt;
`endif
      b0 = beat_cnt; s0 = start_cnt; d0 = done_cnt;
      @(negedge clk);
      check_val({nm, "_busy_idle"}, {63'd0, bus.busy}, 64'd0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_val({nm, "_busy_rise"}, {63'd0, bus.busy}, 64'd1);
      if (disturb) begin
         @(negedge clk);
         bus.start = 1'b1;
         spur = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         spur = 1'b0;
         k = 0;
         while ((beat_cnt == b0) && (k < 50)) begin
            @(negedge clk);
            k++;
         end
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; (i < 200) && !got; i++) begin
         @(negedge clk);
         if (done_cnt != d0) got = 1'b1;
      end
      check_val({nm, "_done_seen"}, {63'd0, got}, 64'd1);
      // start coincident with the done pulse must be ignored
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check_val({nm, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
      check_val({nm, "_rd_after"}, {63'd0, bus.hist_rd_en}, 64'd0);
      check_val({nm, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
      check_val({nm, "_start_cnt"}, 64'(start_cnt - s0), 64'd1);
      check_val({nm, "_beats"}, 64'(beat_cnt - b0), 64'd4);
      check_val({nm, "_start_first"}, {63'd0, (b_cyc[b0] > start_cyc)}, 64'd1);
      check_val({nm, "_tot_pix"}, {32'd0, cap_tp}, {32'd0, etp});
      check_val({nm, "_tot_sum"}, {32'd0, cap_ts}, {32'd0, ets});
      check_val({nm, "_tot_hold"}, {32'd0, bus.acc_total_sum}, {32'd0, ets});
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("%s_cc%0d", nm, i), {32'd0, b_cc[b0+i]}, {32'd0, exp_cc[i]});
         check_val($sformatf("%s_cs%0d", nm, i), {32'd0, b_cs[b0+i]}, {32'd0, exp_cs[i]});
         check_val($sformatf("%s_last%0d", nm, i), {63'd0, b_last[b0+i]}, {63'd0, (i == 3)});
      end
`ifdef OTSU_SWEEP_HIST_CLEAR_EN
      check_val({nm, "_wr_cnt"}, 64'(wr_cnt - w0), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("%s_wa%0d", nm, i), {62'd0, w_addr[w0+i]}, 64'(i));
         check_val($sformatf("%s_wd%0d", nm, i), {32'd0, w_data[w0+i]}, 64'd0);
      end
`endif
   endtask

   initial begin
      int b0, d0, k;
      bit got;
      bus.start = 1'b0;
      bz.start  = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
      check_val("rst_done", {63'd0, bus.done}, 64'd0);
      check_val("rst_rd_en", {63'd0, bus.hist_rd_en}, 64'd0);
      check_val("rst_addr", {62'd0, bus.hist_addr}, 64'd0);
      check_val("rst_acc_start", {63'd0, bus.acc_start}, 64'd0);
      check_val("rst_valid", {63'd0, bus.acc_valid}, 64'd0);
      check_val("rst_last", {63'd0, bus.acc_last}, 64'd0);
      check_val("rst_tp", {32'd0, bus.acc_total_pixels}, 64'd0);
      check_val("rst_cs", {32'd0, bus.acc_cum_sum}, 64'd0);
      rst_n = 1'b1;

      // basic sweep
      load_hist(32'd1, 32'd2, 32'd3, 32'd4);
      exp_cc = '{32'd1, 32'd3, 32'd6, 32'd10};
      exp_cs = '{32'd0, 32'd2, 32'd8, 32'd20};
      run_sweep("basic", 1'b0, 32'd10, 32'd20);

      // start re-pulsed during TOTAL and STREAM, spurious acc_done in TOTAL
      load_hist(32'd4, 32'd3, 32'd2, 32'd1);
      exp_cc = '{32'd4, 32'd7, 32'd9, 32'd10};
      exp_cs = '{32'd0, 32'd3, 32'd7, 32'd10};
      run_sweep("restart", 1'b1, 32'd10, 32'd10);

      // intensity sum wraps: 3*0x60000000 = 0x1_2000_0000
      load_hist(32'd0, 32'd0, 32'd0, 32'h6000_0000);
      exp_cc = '{32'd0, 32'd0, 32'd0, 32'h6000_0000};
      exp_cs = '{32'd0, 32'd0, 32'd0, 32'h2000_0000};
      run_sweep("wrap", 1'b0, 32'h6000_0000, 32'h2000_0000);

      // reset on streaming beat 2, then a clean sweep
      load_hist(32'd9, 32'd9, 32'd9, 32'd9);
      b0 = beat_cnt; d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while ((beat_cnt - b0 < 2) && (k < 100)) begin
         @(negedge clk);
         k++;
      end
      check_val("abort_reached_beat2", 64'(beat_cnt - b0), 64'd2);
      rst_n = 1'b0;
      #1;
      check_val("abort_busy", {63'd0, bus.busy}, 64'd0);
      check_val("abort_valid", {63'd0, bus.acc_valid}, 64'd0);
      check_val("abort_cc", {32'd0, bus.acc_cum_count}, 64'd0);
      check_val("abort_tp", {32'd0, bus.acc_total_pixels}, 64'd0);
      check_val("abort_rd_en", {63'd0, bus.hist_rd_en}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_val("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check_val("abort_idle", {63'd0, bus.busy}, 64'd0);
      load_hist(32'd2, 32'd0, 32'd0, 32'd1);
      exp_cc = '{32'd2, 32'd2, 32'd2, 32'd3};
      exp_cs = '{32'd0, 32'd0, 32'd0, 32'd3};
      run_sweep("recover", 1'b0, 32'd3, 32'd3);

      // histogram clear-on-stream (or left untouched in the default build)
      load_hist(32'd5, 32'd6, 32'd7, 32'd8);
      exp_cc = '{32'd5, 32'd11, 32'd18, 32'd26};
      exp_cs = '{32'd0, 32'd6, 32'd20, 32'd44};
      run_sweep("clr1", 1'b0, 32'd26, 32'd44);
`ifdef OTSU_SWEEP_HIST_CLEAR_EN
      for (int i = 0; i < 4; i++)
         check_val($sformatf("clr_mem%0d", i), {32'd0, mem[i]}, 64'd0);
      exp_cc = '{32'd0, 32'd0, 32'd0, 32'd0};
      exp_cs = '{32'd0, 32'd0, 32'd0, 32'd0};
      run_sweep("clr2", 1'b0, 32'd0, 32'd0);
`else
      for (int i = 0; i < 4; i++)
         check_val($sformatf("keep_mem%0d", i), {32'd0, mem[i]}, 64'(i + 5));
      run_sweep("clr2", 1'b0, 32'd26, 32'd44);
`endif

      // 256-bin all-zero histogram, acc_done held high throughout
      @(negedge clk);
      bz.start = 1'b1;
      @(negedge clk);
      bz.start = 1'b0;
      check_val("z_busy_rise", {63'd0, bz.busy}, 64'd1);
      got = 1'b0;
      for (int i = 0; (i < 1000) && !got; i++) begin
         @(negedge clk);
         if (zdone != 0) got = 1'b1;
      end
      check_val("z_done_seen", {63'd0, got}, 64'd1);
      repeat (3) @(negedge clk);
      check_val("z_beats", 64'(zbeats), 64'd256);
      check_val("z_last_cnt", 64'(zlast_cnt), 64'd1);
      check_val("z_last_idx", 64'(zlast_idx), 64'd255);
      check_val("z_nonzero", 64'(znz), 64'd0);
      check_val("z_start_cnt", 64'(zstart), 64'd1);
      check_val("z_done_cnt", 64'(zdone), 64'd1);
      check_val("z_tp", {32'd0, ztp}, 64'd0);
      check_val("z_ts", {32'd0, zts}, 64'd0);
      check_val("z_busy_after", {63'd0, bz.busy}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/otsu_sweep_controller.md
Name: otsu_sweep_controller

Overview:
- Sequences one Otsu threshold sweep over a histogram RAM.
- Pass 1 reads every bin and forms the totals: pixel count and intensity sum.
- Pass 2 re-reads every bin and streams the running cumulative count and sum into the downstream prefix-accumulator stage, using start/valid/last.
- Sits between the histogram memory and the prefix-accumulator/variance datapath.

Parameters:
- BIN_WIDTH, 8, bin address width; NUM_BINS = 2**BIN_WIDTH.
- COUNT_WIDTH, 32, width of bin counts, cumulative counts and total counts.
- INTENSITY_WIDTH, 32, width of intensity sums.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sweep
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the sweep completes
- hist_rd_en  out  1  histogram read strobe
- hist_addr  out  BIN_WIDTH  histogram read address
- hist_data  in  COUNT_WIDTH  bin count; valid 1 cycle after hist_rd_en
- acc_start  out  1  one-cycle start pulse to the accumulator
- acc_total_pixels  out  COUNT_WIDTH  total pixel count
- acc_total_sum  out  INTENSITY_WIDTH  total intensity sum
- acc_cum_count  out  COUNT_WIDTH  cumulative count, inclusive of the current bin
- acc_cum_sum  out  INTENSITY_WIDTH  cumulative intensity, inclusive of the current bin
- acc_valid  out  1  cumulative beat valid
- acc_last  out  1  marks the beat for bin NUM_BINS-1
- acc_done  in  1  accumulator completion pulse

Behaviour:
- Reset values: every output is 0. State is IDLE. All internal accumulators are 0.
- Reset asserted mid-sweep:
  - Immediate abort to IDLE with all outputs at 0.
  - No done pulse is issued.
  - A partial stream is not resumed.
- Read pipeline:
  - The address is issued with hist_rd_en in cycle n; hist_data is consumed in cycle n+1.
  - A registered rd_valid/rd_last flag pair tracks reads in flight.
- States and transitions:
  - IDLE: start=1 -> TOTAL. Clears the totals and addr=0. busy rises next cycle.
  - TOTAL:
    - Issues reads for addr 0..NUM_BINS-1, one per cycle.
    - Each returned beat adds hist_data to total_pixels, and addr*hist_data to total_sum, using the returned bin's index.
    - When the beat for the last bin returns -> ARM.
    - Duration is NUM_BINS+1 cycles.
  - ARM:
    - acc_start=1 for exactly one cycle.
    - acc_total_pixels and acc_total_sum take the totals and hold them stable until IDLE.
    - The cumulative registers are cleared and addr=0. -> STREAM.
  - STREAM:
    - Issues NUM_BINS reads back-to-back.
    - Each returned beat adds to the cumulatives and drives acc_valid=1 in the same cycle as the registered output.
    - acc_cum_* include the current bin.
    - acc_last=1 only with the bin NUM_BINS-1 beat.
    - After the last beat -> WAIT_ACC.
    - Exactly NUM_BINS valid beats are produced, with no gaps and no backpressure.
  - WAIT_ACC: holds until acc_done=1 -> DONE.
  - DONE: done=1 for one cycle, busy falls. -> IDLE.
- start while busy is ignored and never queued.
- start in the same cycle as the done pulse is ignored; start is accepted from IDLE only.
- Arithmetic and width rules:
  - The product addr*hist_data is computed at BIN_WIDTH+COUNT_WIDTH bits.
  - All sums truncate modulo 2^width. There is no saturation and no error flag.
- Empty histogram: totals are 0 and NUM_BINS beats of zeros are still streamed. done occurs normally.
- A spurious acc_done outside WAIT_ACC is ignored.

Optional Feature:
- Macro: OTSU_SWEEP_HIST_CLEAR_EN
- Defined:
  - Adds ports hist_wr_en (out, 1), hist_wr_addr (out, BIN_WIDTH) and hist_wr_data (out, COUNT_WIDTH), all reset to 0.
  - In STREAM, the cycle each bin's data returns, the controller writes 0 to that bin address.
  - After done, the RAM is all-zero, ready for the next frame with no extra clear cycles.
  - A write is never issued in TOTAL.
- Undefined: the write ports do not exist, and the histogram is left unmodified.

Decomposition:
- Shared package otsu_pkg holds:
  - The state enum: IDLE, TOTAL, ARM, STREAM, WAIT_ACC, DONE.
  - The default width constants.
  - The NUM_BINS derivation function.
- One natural sub-module, bin_scan_sequencer. It holds:
  - The address counter, hist_rd_en generation and the 1-cycle rd_valid/rd_last pipeline.
  - Start/last-issued handshakes.
  - The same instance is reused by both TOTAL and STREAM.

Test Plan:
1. BIN_WIDTH=2, hist=[1,2,3,4], acc_done 2 cycles after acc_last -> acc_total_pixels=10, acc_total_sum=20; beats (cum_count,cum_sum)=(1,0),(3,2),(6,8),(10,20); acc_last on beat 4 only; one done pulse; acc_start exactly once, before the first beat.
2. All-zero histogram, BIN_WIDTH=8 -> 256 beats all (0,0), totals 0, acc_last on beat 256, done issued.
3. start re-pulsed during TOTAL and during STREAM -> no restart; beat count still exactly NUM_BINS; single done.
4. rst_n asserted on STREAM beat 2 -> all outputs 0 asynchronously; a later start gives the full correct sweep with totals not polluted by the aborted run.
5. COUNT_WIDTH=INTENSITY_WIDTH=8, hist=[0,0,0,200] with BIN_WIDTH=2 -> total_sum=600 mod 256=88; total_pixels=200 with no overflow; last beat cum_sum=88.
6. HIST_CLEAR_EN defined, hist=[5,6,7,8] -> hist_wr_en high for 4 cycles, addrs 0..3, data 0; RAM all zero after done; a second sweep yields totals 0.
